bus_dma: RTL and testbench
==========================

BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 Parameters: none; the block is fixed-width for the 16-bit address, 8-bit data system bus.
REQ-002 clk_i  input  1  system clock; all logic on rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 reg_cs_i  input  1  CPU selects the DMA register window.
REQ-005 reg_addr_i  input  3  register index 0-7.
REQ-006 reg_r_w_n_i  input  1  CPU access direction: 1 = read, 0 = write.
REQ-007 reg_data_i  input  8  CPU write data.
REQ-008 reg_data_o  output  8  register read data, combinational from reg_addr_i.
REQ-009 bus_req_o  output  1  request for system bus mastership; CPU halted while bus_gnt_i is high.
REQ-010 bus_gnt_i  input  1  bus granted to DMA.
REQ-011 addr_o  output  16  master address.
REQ-012 r_w_n_o  output  1  master direction: 1 = read, 0 = write.
REQ-013 data_o  output  8  master write data.
REQ-014 data_i  input  8  master read data; valid one cycle after address (synchronous memory).
REQ-015 irq_o  output  1  completion interrupt, level.

Function
REQ-016 Registers SHALL be: 0 SRC_L, 1 SRC_H, 2 DST_L, 3 DST_H, 4 LEN_L, 5 LEN_H, 6 CTRL, 7 STATUS.
REQ-017 CTRL bits SHALL be: b0 START (write-1 pulse, reads 0), b1 IRQ_EN, b2 SRC_FIX (no source increment), b3 DST_FIX (no destination increment), b7 ABORT (write-1 pulse, reads 0).
REQ-018 STATUS bits SHALL be: b0 BUSY, b1 DONE, b2 ABORTED; writing 1 to b1 SHALL clear DONE and ABORTED.
REQ-019 Writes SHALL take effect on the clock edge where reg_cs_i=1 and reg_r_w_n_i=0.
REQ-020 Writes to registers 0-5 and to IRQ_EN, SRC_FIX and DST_FIX SHALL be ignored while BUSY=1.
REQ-021 Registers 0-5 SHALL read back the live working values, so a transfer in progress is visible.
REQ-022 FSM states SHALL be: IDLE, REQ, RD, RDW, WR.
- IDLE -> REQ on START with LEN!=0.
- START with LEN=0 SHALL set DONE immediately and stay in IDLE.
REQ-023 REQ SHALL assert bus_req_o and move to RD on the first cycle bus_gnt_i=1.
REQ-024 RD SHALL drive addr_o=SRC, r_w_n_o=1, then go to RDW.
REQ-025 RDW SHALL keep addr_o=SRC, capture data_i into a byte latch at the end of the cycle, then go to WR.
REQ-026 WR SHALL drive addr_o=DST, r_w_n_o=0, data_o=latch for one cycle.
REQ-027 At the end of WR the block SHALL:
- increment SRC unless SRC_FIX;
- increment DST unless DST_FIX;
- decrement LEN.
REQ-028 After WR the FSM SHALL go to IDLE with DONE=1 if the new LEN=0.
REQ-029 Otherwise after WR it SHALL go to RD if bus_gnt_i=1, else to REQ.
REQ-030 Throughput SHALL be 3 cycles per byte while granted; bus_req_o SHALL stay high in REQ, RD, RDW and WR.
REQ-031 Address arithmetic SHALL be 16-bit modulo: 0xFFFF+1 = 0x0000.
REQ-032 LEN SHALL NOT underflow; LEN is never 0 when WR is entered.
REQ-033 bus_gnt_i falling during RD or RDW SHALL return the FSM to REQ without a write; the same byte is re-read once the grant returns.
REQ-034 A grant drop in WR SHALL NOT abort that write cycle.
REQ-035 ABORT SHALL:
- force IDLE on the next edge from any state;
- set ABORTED=1;
- leave DONE=0;
- keep SRC, DST and LEN at their current values.
REQ-036 A WR cycle in progress when ABORT is written SHALL complete on that edge before IDLE is entered.
REQ-037 START while BUSY=1 SHALL be ignored.
REQ-038 START and ABORT in the same write SHALL be treated as ABORT only.
REQ-039 When not in RD, RDW or WR the block SHALL drive addr_o=0x0000, r_w_n_o=1, data_o=0x00.
REQ-040 BUSY SHALL be 1 in every state except IDLE.
REQ-041 irq_o SHALL equal IRQ_EN & (DONE | ABORTED).

Reset
REQ-042 On rst_n_i=0 the block SHALL:
- enter IDLE;
- clear all registers, CTRL bits, the byte latch and STATUS to 0;
- drive bus_req_o=0, addr_o=0x0000, r_w_n_o=1, data_o=0x00, irq_o=0.
REQ-043 Reset asserted mid-transfer SHALL release bus_req_o asynchronously, with no further bus cycles after deassertion.

Verification
REQ-044 SRC=0x1000, DST=0x2000, LEN=3, START with bus_gnt_i tied 1 -> reads 0x1000-0x1002 and writes 0x2000-0x2002 with the matching data; DONE=1 after 9+1 cycles; LEN reads 0.
REQ-045 SRC=0xFFFF, DST=0x3000, LEN=2 -> second read address is 0x0000.
REQ-046 SRC_FIX=1, SRC=0xFE00, LEN=4 -> four reads of 0xFE00; DST increments 4 times.
REQ-047 Drop bus_gnt_i during RDW of byte 2 for 5 cycles -> no write in that window; byte 2 is re-read after re-grant; the destination contents are correct.
REQ-048 ABORT after 2 bytes of LEN=10 with IRQ_EN=1 -> IDLE, ABORTED=1, DONE=0, LEN=8, irq_o=1; writing 0x02 to STATUS clears irq_o.
REQ-049 LEN=0 with START -> DONE=1 next cycle, bus_req_o never asserted.

Source files
------------

// File: rtl/bus_dma.sv
// bus_dma: single-channel memory-to-memory DMA for a 16-bit address, 8-bit data bus.
//   clk_i, rst_n_i      clock (rising edge) and asynchronous active-low reset
//   reg_cs_i, reg_addr_i, reg_r_w_n_i, reg_data_i, reg_data_o
//                       CPU register window: SRC/DST/LEN bytes, CTRL, STATUS
//   bus_req_o, bus_gnt_i  bus mastership handshake
//   addr_o, r_w_n_o, data_o, data_i  master port (synchronous memory, read data one cycle late)
//   irq_o               level interrupt on DONE or ABORTED when IRQ_EN is set
module bus_dma (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        reg_cs_i,
   input  logic [2:0]  reg_addr_i,
   input  logic        reg_r_w_n_i,
   input  logic [7:0]  reg_data_i,
   output logic [7:0]  reg_data_o,
   output logic        bus_req_o,
   input  logic        bus_gnt_i,
   output logic [15:0] addr_o,
   output logic        r_w_n_o,
   output logic [7:0]  data_o,
   input  logic [7:0]  data_i,
   output logic        irq_o
);
   typedef enum logic [2:0] {IDLE, REQ, RD, RDW, WR} state_t;
   state_t state, state_nxt;
   logic [15:0] src, dst, len;
   logic [7:0]  latch;
   logic        irq_en, src_fix, dst_fix, done, aborted;
   logic        reg_wr, busy, start, abort, len_last;
   assign reg_wr   = reg_cs_i & ~reg_r_w_n_i;
   assign busy     = state != IDLE;
   assign abort    = reg_wr && reg_addr_i == 3'd6 && reg_data_i[7];
   // ABORT takes priority over START written in the same access
   assign start    = reg_wr && reg_addr_i == 3'd6 && reg_data_i[0] && !reg_data_i[7];
   // LEN is never 0 in WR, so LEN==1 there means this is the last byte
   assign len_last = len == 16'd1;
   assign irq_o    = irq_en & (done | aborted);
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      bus_req_o = busy;
      addr_o    = 16'h0000;
      r_w_n_o   = 1'b1;
      data_o    = 8'h00;
      case (state)
         IDLE: state_nxt = (start && len != 16'd0) ? REQ : IDLE;
         REQ:  state_nxt = bus_gnt_i ? RD : REQ;
         RD: begin
            addr_o    = src;
            state_nxt = bus_gnt_i ? RDW : REQ;
         end
         RDW: begin
            addr_o    = src;
            state_nxt = bus_gnt_i ? WR : REQ;
         end
         WR: begin
            addr_o    = dst;
            r_w_n_o   = 1'b0;
            data_o    = latch;
            state_nxt = len_last ? IDLE : (bus_gnt_i ? RD : REQ);
         end
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         src     <= 16'h0000;
         dst     <= 16'h0000;
         len     <= 16'h0000;
         latch   <= 8'h00;
         irq_en  <= 1'b0;
         src_fix <= 1'b0;
         dst_fix <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         if (reg_wr && !busy) begin
            case (reg_addr_i)
               3'd0: src[7:0]  <= reg_data_i;
               3'd1: src[15:8] <= reg_data_i;
               3'd2: dst[7:0]  <= reg_data_i;
               3'd3: dst[15:8] <= reg_data_i;
               3'd4: len[7:0]  <= reg_data_i;
               3'd5: len[15:8] <= reg_data_i;
               3'd6: {dst_fix, src_fix, irq_en} <= reg_data_i[3:1];
               default: ;
            endcase
         end
         if (reg_wr && reg_addr_i == 3'd7 && reg_data_i[1]) begin
            done    <= 1'b0;
            aborted <= 1'b0;
         end
         if (!busy && start && len == 16'd0) done <= 1'b1;
         if (state == RDW) latch <= data_i;
         // a WR in flight always completes, even on the ABORT edge
         if (state == WR) begin
            src <= src_fix ? src : src + 16'd1;
            dst <= dst_fix ? dst : dst + 16'd1;
            len <= len - 16'd1;
            if (len_last) done <= 1'b1;
         end
         if (abort) begin
            done    <= 1'b0;
            aborted <= 1'b1;
         end
      end
   end
   always_comb begin
      case (reg_addr_i)
         3'd0:    reg_data_o = src[7:0];
         3'd1:    reg_data_o = src[15:8];
         3'd2:    reg_data_o = dst[7:0];
         3'd3:    reg_data_o = dst[15:8];
         3'd4:    reg_data_o = len[7:0];
         3'd5:    reg_data_o = len[15:8];
         3'd6:    reg_data_o = {4'b0000, dst_fix, src_fix, irq_en, 1'b0};
         default: reg_data_o = {5'b00000, aborted, done, busy};
      endcase
   end
endmodule

// File: tb/tb_bus_dma.sv
// tb_bus_dma: directed, table-driven bench for bus_dma with a synchronous memory model.
module tb_bus_dma;
   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        reg_cs_i = 1'b0;
   logic [2:0]  reg_addr_i = 3'd0;
   logic        reg_r_w_n_i = 1'b1;
   logic [7:0]  reg_data_i = 8'h00;
   logic [7:0]  reg_data_o;
   logic        bus_req_o;
   logic        bus_gnt_i = 1'b0;
   logic [15:0] addr_o;
   logic        r_w_n_o;
   logic [7:0]  data_o;
   logic [7:0]  data_i = 8'h00;
   logic        irq_o;

   bus_dma dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .reg_cs_i(reg_cs_i), .reg_addr_i(reg_addr_i),
      .reg_r_w_n_i(reg_r_w_n_i), .reg_data_i(reg_data_i), .reg_data_o(reg_data_o),
      .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .addr_o(addr_o), .r_w_n_o(r_w_n_o),
      .data_o(data_o), .data_i(data_i), .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
   endfunction

   // memory model: writes and logging on the falling edge, read data registered from the address
   logic [7:0]  mem [65536];
   logic [15:0] log_src [256];
   logic [15:0] log_dst [256];
   logic [7:0]  log_dat [256];
   logic [15:0] prev_addr = 16'h0000;
   int          wr_cnt = 0;
   int          req_cycles = 0;

   always @(negedge clk_i) begin
      if (bus_req_o) req_cycles++;
      if (!r_w_n_o) begin
         if (wr_cnt < 256) begin
            log_src[wr_cnt] = prev_addr;
            log_dst[wr_cnt] = addr_o;
            log_dat[wr_cnt] = data_o;
         end
         mem[addr_o] = data_o;
         wr_cnt++;
      end
      data_i = mem[addr_o];
      prev_addr = addr_o;
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk_i);
      reg_cs_i = 1'b1;
      reg_r_w_n_i = 1'b0;
      reg_addr_i = a;
      reg_data_i = d;
      @(posedge clk_i);
      #1;
      reg_cs_i = 1'b0;
      reg_r_w_n_i = 1'b1;
   endtask

   task automatic check_reg(input string name, input logic [2:0] a, input logic [7:0] exp);
      reg_addr_i = a;
      reg_r_w_n_i = 1'b1;
      reg_cs_i = 1'b1;
      #1;
      check(name, reg_data_o, exp);
      reg_cs_i = 1'b0;
   endtask

   task automatic set_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
      reg_wr(3'd0, s[7:0]);
      reg_wr(3'd1, s[15:8]);
      reg_wr(3'd2, d[7:0]);
      reg_wr(3'd3, d[15:8]);
      reg_wr(3'd4, l[7:0]);
      reg_wr(3'd5, l[15:8]);
   endtask

   task automatic wait_idle(input string name, input int maxc);
      int n;
      for (n = 0; n < maxc; n++) begin
         @(posedge clk_i);
         #1;
         reg_addr_i = 3'd7;
         #1;
         if (reg_data_o[0] == 1'b0) break;
      end
      check(name, n < maxc, 1);
   endtask

   typedef struct {
      logic       wr;
      logic [2:0] a;
      logic [7:0] d;
   } vec_t;
   vec_t tbl [$];

   int base;
   int w0;

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
      for (int i = 0; i < 8; i++) tbl.push_back('{1'b0, 3'(i), 8'h00});
      tbl.push_back('{1'b1, 3'd0, 8'h34});
      tbl.push_back('{1'b1, 3'd1, 8'h12});
      tbl.push_back('{1'b1, 3'd2, 8'h78});
      tbl.push_back('{1'b1, 3'd3, 8'h56});
      tbl.push_back('{1'b1, 3'd4, 8'h05});
      tbl.push_back('{1'b1, 3'd5, 8'h01});
      tbl.push_back('{1'b1, 3'd6, 8'h0E});
      tbl.push_back('{1'b0, 3'd0, 8'h34});
      tbl.push_back('{1'b0, 3'd1, 8'h12});
      tbl.push_back('{1'b0, 3'd2, 8'h78});
      tbl.push_back('{1'b0, 3'd3, 8'h56});
      tbl.push_back('{1'b0, 3'd4, 8'h05});
      tbl.push_back('{1'b0, 3'd5, 8'h01});
      tbl.push_back('{1'b0, 3'd6, 8'h0E});
      tbl.push_back('{1'b0, 3'd7, 8'h00});
      tbl.push_back('{1'b1, 3'd6, 8'h00});
      tbl.push_back('{1'b0, 3'd6, 8'h00});

      repeat (3) @(posedge clk_i);
      #1;
      check("rst_bus_req", bus_req_o, 0);
      check("rst_addr", addr_o, 16'h0000);
      check("rst_r_w_n", r_w_n_o, 1);
      check("rst_data", data_o, 8'h00);
      check("rst_irq", irq_o, 0);
      @(negedge clk_i);
      rst_n_i = 1'b1;

      foreach (tbl[i]) begin
         if (tbl[i].wr) reg_wr(tbl[i].a, tbl[i].d);
         else check_reg($sformatf("vec%0d_reg%0d", i, tbl[i].a), tbl[i].a, tbl[i].d);
      end

      // basic three-byte copy with continuous grant
      bus_gnt_i = 1'b1;
      set_xfer(16'h1000, 16'h2000, 16'd3);
      base = wr_cnt;
      reg_wr(3'd6, 8'h01);
      reg_addr_i = 3'd7;
      repeat (9) @(posedge clk_i);
      #1;
      check("copy_busy_at_9", reg_data_o, 8'h01);
      @(posedge clk_i);
      #1;
      check("copy_done_at_10", reg_data_o, 8'h02);
      check("copy_bus_req_off", bus_req_o, 0);
      check("copy_writes", wr_cnt - base, 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("copy_src%0d", i), log_src[base + i], 16'h1000 + 16'(i));
         check($sformatf("copy_dst%0d", i), log_dst[base + i], 16'h2000 + 16'(i));
         check($sformatf("copy_dat%0d", i), log_dat[base + i], pat(16'h1000 + 16'(i)));
      end
      check_reg("copy_len_l", 3'd4, 8'h00);
      check_reg("copy_len_h", 3'd5, 8'h00);
      check_reg("copy_src_l", 3'd0, 8'h03);
      check_reg("copy_dst_l", 3'd2, 8'h03);
      check("copy_irq_disabled", irq_o, 0);
      reg_wr(3'd7, 8'h02);
      check_reg("copy_status_clr", 3'd7, 8'h00);

      // source address wrap
      set_xfer(16'hFFFF, 16'h3000, 16'd2);
      base = wr_cnt;
      reg_wr(3'd6, 8'h01);
      wait_idle("wrap_timeout", 50);
      check("wrap_src0", log_src[base], 16'hFFFF);
      check("wrap_src1", log_src[base + 1], 16'h0000);
      check("wrap_mem1", mem[16'h3001], pat(16'h0000));
      check_reg("wrap_src_l", 3'd0, 8'h01);
      check_reg("wrap_src_h", 3'd1, 8'h00);
      reg_wr(3'd7, 8'h02);

      // fixed source
      reg_wr(3'd6, 8'h04);
      set_xfer(16'hFE00, 16'h4000, 16'd4);
      base = wr_cnt;
      reg_wr(3'd6, 8'h05);
      wait_idle("fix_timeout", 50);
      check("fix_writes", wr_cnt - base, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("fix_src%0d", i), log_src[base + i], 16'hFE00);
         check($sformatf("fix_dst%0d", i), log_dst[base + i], 16'h4000 + 16'(i));
      end
      check_reg("fix_src_h", 3'd1, 8'hFE);
      check_reg("fix_src_l", 3'd0, 8'h00);
      check_reg("fix_dst_l", 3'd2, 8'h04);
      reg_wr(3'd7, 8'h02);
      reg_wr(3'd6, 8'h00);

      // grant drop during RDW of the second byte
      set_xfer(16'h5000, 16'h6000, 16'd4);
      base = wr_cnt;
      reg_wr(3'd6, 8'h01);
      repeat (5) @(posedge clk_i);
      #1;
      check("drop_rdw_addr", addr_o, 16'h5001);
      check("drop_rdw_dir", r_w_n_o, 1);
      bus_gnt_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #1;
      check("drop_no_write", wr_cnt - base, 1);
      check("drop_bus_req_held", bus_req_o, 1);
      check("drop_req_addr", addr_o, 16'h0000);
      bus_gnt_i = 1'b1;
      wait_idle("drop_timeout", 50);
      check("drop_writes", wr_cnt - base, 4);
      check("drop_reread_src", log_src[base + 1], 16'h5001);
      for (int i = 0; i < 4; i++)
         check($sformatf("drop_mem%0d", i), mem[16'h6000 + 16'(i)], pat(16'h5000 + 16'(i)));
      reg_wr(3'd7, 8'h02);

      // abort during the WR of the second byte, interrupts enabled
      reg_wr(3'd6, 8'h02);
      set_xfer(16'h7000, 16'h8000, 16'd10);
      base = wr_cnt;
      reg_wr(3'd6, 8'h03);
      repeat (6) @(posedge clk_i);
      reg_wr(3'd6, 8'h80);
      check_reg("abort_status", 3'd7, 8'h04);
      check_reg("abort_len_l", 3'd4, 8'h08);
      check_reg("abort_len_h", 3'd5, 8'h00);
      check_reg("abort_src_l", 3'd0, 8'h02);
      check_reg("abort_dst_l", 3'd2, 8'h02);
      check("abort_irq", irq_o, 1);
      check("abort_bus_req", bus_req_o, 0);
      check("abort_writes", wr_cnt - base, 2);
      reg_wr(3'd7, 8'h02);
      check("abort_irq_clr", irq_o, 0);
      check_reg("abort_status_clr", 3'd7, 8'h00);
      reg_wr(3'd6, 8'h00);

      // zero length
      set_xfer(16'h9000, 16'hA000, 16'd0);
      w0 = req_cycles;
      reg_wr(3'd6, 8'h01);
      check_reg("zero_status", 3'd7, 8'h02);
      repeat (5) @(posedge clk_i);
      #1;
      check("zero_no_req", req_cycles - w0, 0);
      check("zero_bus_req", bus_req_o, 0);
      reg_wr(3'd7, 8'h02);

      // reset mid-transfer
      set_xfer(16'h9000, 16'hA000, 16'd5);
      reg_wr(3'd6, 8'h01);
      repeat (4) @(posedge clk_i);
      #3;
      check("mid_rst_pre_req", bus_req_o, 1);
      rst_n_i = 1'b0;
      #1;
      check("mid_rst_req_async", bus_req_o, 0);
      check("mid_rst_addr", addr_o, 16'h0000);
      check("mid_rst_dir", r_w_n_o, 1);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      w0 = wr_cnt;
      repeat (10) @(posedge clk_i);
      #1;
      check("mid_rst_no_write", wr_cnt - w0, 0);
      check("mid_rst_idle", bus_req_o, 0);
      check_reg("mid_rst_status", 3'd7, 8'h00);
      check_reg("mid_rst_len", 3'd4, 8'h00);
      check_reg("mid_rst_src_h", 3'd1, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
